// File: rtl/calc_sequencer_if.sv
// rtl/calc_sequencer_if.sv - keypad and ALU handshake bundle for calc_sequencer
// The master side is the sequencer; the slave side is the keypad front end plus ALU.
interface calc_sequencer_if #(
  parameter int WIDTH = 16
) ();
  logic             key_valid;
  logic [1:0]       key_type;
  logic [3:0]       key_data;
  logic             key_ack;

  logic             alu_start;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic             alu_done;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;

  modport master (
    input  key_valid, key_type, key_data, alu_done, alu_result, alu_ovf,
    output key_ack, alu_start, alu_a, alu_b, alu_op
  );

  modport slave (
    output key_valid, key_type, key_data, alu_done, alu_result, alu_ovf,
    input  key_ack, alu_start, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - calculator key sequencer driving a shared multi-cycle ALU
// Builds signed decimal operands from key events and runs one ALU transaction per evaluation.
module calc_sequencer #(
  parameter int WIDTH       = 16,
  parameter int MAX_DIGITS  = 4,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               nRST,
  calc_sequencer_if.master   bus,
  output logic [WIDTH-1:0]   display_output,
  output logic               complete,
  output logic               error,
  output logic [2:0]         state
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = (ALU_TIMEOUT > 2) ? $clog2(ALU_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ENTER_OP = 3'd1,
    ENTER_B  = 3'd2,
    EXEC     = 3'd3,
    WAIT_ALU = 3'd4,
    SHOW     = 3'd5,
    ERR      = 3'd6
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [2:0]       pend_op_q;
  logic             pend_q;
  logic [CW-1:0]    cnt_a_q;
  logic [CW-1:0]    cnt_b_q;
  logic [TW-1:0]    tmo_q;
  logic             key_ack_q;
  logic             alu_start_q;
  logic             complete_q;
  logic             error_q;
  logic [WIDTH-1:0] disp_hold_q;

  logic [WIDTH-1:0] a_push_d;
  logic [WIDTH-1:0] b_push_d;
  logic [WIDTH-1:0] disp_d;
  logic             accept;
  logic             k_digit;
  logic             k_oper;
  logic             k_equal;
  logic             k_clear;
  logic             k_neg;
  logic             d_ok;

  // Sign-aware decimal shift: negative operands grow away from zero.
  function automatic logic [WIDTH-1:0] push_digit(input logic [WIDTH-1:0] v,
                                                  input logic [3:0]       d);
    logic [WIDTH-1:0] x10;
    logic [WIDTH-1:0] dx;
    x10 = (v << 3) + (v << 1);
    dx  = {{(WIDTH-4){1'b0}}, d};
    return v[WIDTH-1] ? (x10 - dx) : (x10 + dx);
  endfunction

  assign k_digit = (bus.key_type == 2'b00);
  assign k_oper  = (bus.key_type == 2'b01);
  assign k_equal = (bus.key_type == 2'b10);
  assign k_clear = (bus.key_type == 2'b11);
  assign k_neg   = (bus.key_data[2:0] == 3'b111);
  assign d_ok    = (bus.key_data <= 4'd9);

  assign accept = bus.key_valid && !key_ack_q &&
                  (state_q inside {ENTER_A, ENTER_OP, ENTER_B, SHOW, ERR});

  assign a_push_d = push_digit(a_q, bus.key_data);
  assign b_push_d = push_digit(b_q, bus.key_data);

  // EXEC/WAIT_ALU keep showing whatever was on screen when evaluation began.
  always_comb begin
    disp_d = disp_hold_q;
    case (state_q)
      ENTER_A, ENTER_OP, SHOW: disp_d = a_q;
      ENTER_B:                 disp_d = b_q;
      ERR:                     disp_d = '0;
      default:                 disp_d = disp_hold_q;
    endcase
  end

  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      state_q     <= ENTER_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      pend_op_q   <= '0;
      pend_q      <= 1'b0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      tmo_q       <= '0;
      key_ack_q   <= 1'b0;
      alu_start_q <= 1'b0;
      complete_q  <= 1'b0;
      error_q     <= 1'b0;
      disp_hold_q <= '0;
    end else begin
      key_ack_q   <= 1'b0;
      alu_start_q <= 1'b0;
      if (state_q != EXEC && state_q != WAIT_ALU)
        disp_hold_q <= disp_d;

      case (state_q)
        EXEC: begin
          alu_start_q <= 1'b1;
          tmo_q       <= '0;
          state_q     <= WAIT_ALU;
        end

        WAIT_ALU: begin
          if (bus.alu_done) begin
            if (bus.alu_ovf) begin
              error_q <= 1'b1;
              pend_q  <= 1'b0;
              state_q <= ERR;
            end else begin
              a_q <= bus.alu_result;
              if (pend_q) begin
                op_q    <= pend_op_q;
                pend_q  <= 1'b0;
                state_q <= ENTER_OP;
              end else begin
                complete_q <= 1'b1;
                state_q    <= SHOW;
              end
            end
          end else if (tmo_q == TW'(ALU_TIMEOUT - 1)) begin
            error_q <= 1'b1;
            pend_q  <= 1'b0;
            state_q <= ERR;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        default: begin
          if (accept) begin
            key_ack_q <= 1'b1;
            if (k_clear) begin
              a_q        <= '0;
              b_q        <= '0;
              cnt_a_q    <= '0;
              cnt_b_q    <= '0;
              pend_q     <= 1'b0;
              complete_q <= 1'b0;
              error_q    <= 1'b0;
              state_q    <= ENTER_A;
            end else begin
              case (state_q)
                ENTER_A: begin
                  if (k_digit && d_ok && cnt_a_q < CW'(MAX_DIGITS)) begin
                    a_q     <= a_push_d;
                    cnt_a_q <= cnt_a_q + CW'(1);
                  end else if (k_oper && k_neg) begin
                    a_q <= -a_q;
                  end else if (k_oper) begin
                    op_q    <= bus.key_data[2:0];
                    state_q <= ENTER_OP;
                  end else if (k_equal) begin
                    complete_q <= 1'b1;
                    state_q    <= SHOW;
                  end
                end

                ENTER_OP: begin
                  if (k_digit && d_ok) begin
                    b_q     <= {{(WIDTH-4){1'b0}}, bus.key_data};
                    cnt_b_q <= CW'(1);
                    state_q <= ENTER_B;
                  end else if (k_oper && k_neg) begin
                    a_q <= -a_q;
                  end else if (k_oper) begin
                    op_q <= bus.key_data[2:0];
                  end
                end

                ENTER_B: begin
                  if (k_digit && d_ok && cnt_b_q < CW'(MAX_DIGITS)) begin
                    b_q     <= b_push_d;
                    cnt_b_q <= cnt_b_q + CW'(1);
                  end else if (k_oper && k_neg) begin
                    b_q <= -b_q;
                  end else if (k_oper) begin
                    pend_q    <= 1'b1;
                    pend_op_q <= bus.key_data[2:0];
                    state_q   <= EXEC;
                  end else if (k_equal) begin
                    state_q <= EXEC;
                  end
                end

                SHOW: begin
                  if (k_digit && d_ok) begin
                    a_q        <= {{(WIDTH-4){1'b0}}, bus.key_data};
                    cnt_a_q    <= CW'(1);
                    b_q        <= '0;
                    cnt_b_q    <= '0;
                    complete_q <= 1'b0;
                    state_q    <= ENTER_A;
                  end else if (k_oper && k_neg) begin
                    a_q <= -a_q;
                  end else if (k_oper) begin
                    op_q       <= bus.key_data[2:0];
                    complete_q <= 1'b0;
                    state_q    <= ENTER_OP;
                  end else if (k_equal) begin
                    complete_q <= 1'b0;
                    state_q    <= EXEC;
                  end
                end

                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign bus.key_ack   = key_ack_q;
  assign bus.alu_start = alu_start_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;

  assign display_output = disp_d;
  assign complete       = complete_q;
  assign error          = error_q;
  assign state          = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed self-checking bench for calc_sequencer
module tb_calc_sequencer;

  logic        clk;
  logic        nRST;
  logic [15:0] disp;
  logic        complete;
  logic        error;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  int n_ack = 0;

  calc_sequencer_if #(.WIDTH(16)) ifc ();

  calc_sequencer #(
    .WIDTH(16),
    .MAX_DIGITS(4),
    .ALU_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .nRST(nRST),
    .bus(ifc),
    .display_output(disp),
    .complete(complete),
    .error(error),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ifc.alu_start) n_start++;
    if (ifc.key_ack) n_ack++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [1:0] t, input logic [3:0] d);
    int n;
    ifc.key_type  = t;
    ifc.key_data  = d;
    ifc.key_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifc.key_ack && n < 20);
    check("key_ack_seen", ifc.key_ack, 1);
    ifc.key_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!ifc.alu_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("alu_start_seen", ifc.alu_start, 1);
  endtask

  task automatic alu_cycle(input logic [15:0] res, input logic ovf, input int dly,
                           output logic [15:0] ca, output logic [15:0] cb,
                           output logic [2:0] cop);
    wait_start();
    ca = ifc.alu_a;
    cb = ifc.alu_b;
    cop = ifc.alu_op;
    repeat (dly - 1) @(negedge clk);
    ifc.alu_result = res;
    ifc.alu_ovf    = ovf;
    ifc.alu_done   = 1'b1;
    @(negedge clk);
    ifc.alu_done   = 1'b0;
    ifc.alu_ovf    = 1'b0;
  endtask

  initial begin
    logic [15:0] ca, cb;
    logic [2:0]  cop;
    int s0;

    nRST           = 1'b1;
    ifc.key_valid  = 1'b0;
    ifc.key_type   = 2'b00;
    ifc.key_data   = 4'd0;
    ifc.alu_done   = 1'b0;
    ifc.alu_result = 16'd0;
    ifc.alu_ovf    = 1'b0;
    repeat (3) @(negedge clk);
    nRST = 1'b0;
    @(negedge clk);

    check("rst_state", state, 0);
    check("rst_disp", disp, 0);
    check("rst_complete", complete, 0);
    check("rst_error", error, 0);
    check("rst_key_ack", ifc.key_ack, 0);
    check("rst_alu_start", ifc.alu_start, 0);

    // 12 + 7 = 19
    press(2'b00, 4'd1);
    press(2'b00, 4'd2);
    check("t1_disp_a", disp, 12);
    press(2'b01, 4'd0);
    check("t1_state_op", state, 1);
    press(2'b00, 4'd7);
    check("t1_state_b", state, 2);
    check("t1_disp_b", disp, 7);
    s0 = n_start;
    press(2'b10, 4'd0);
    alu_cycle(16'd19, 1'b0, 5, ca, cb, cop);
    check("t1_alu_a", ca, 12);
    check("t1_alu_b", cb, 7);
    check("t1_alu_op", cop, 0);
    check("t1_one_start", n_start - s0, 1);
    check("t1_disp", disp, 19);
    check("t1_complete", complete, 1);
    check("t1_state", state, 5);

    // digit limit and negate
    press(2'b11, 4'd0);
    check("t2_clr_state", state, 0);
    press(2'b00, 4'd9);
    press(2'b00, 4'd8);
    press(2'b00, 4'd7);
    press(2'b00, 4'd6);
    check("t2_disp4", disp, 16'd9876);
    press(2'b00, 4'd5);
    check("t2_disp5", disp, 16'd9876);
    press(2'b01, 4'd7);
    check("t2_neg", disp, 16'hD96C);
    check("t2_state", state, 0);

    // chaining: 5*3 then +4
    press(2'b11, 4'd0);
    press(2'b00, 4'd5);
    press(2'b01, 4'd2);
    press(2'b00, 4'd3);
    press(2'b01, 4'd0);
    alu_cycle(16'd15, 1'b0, 3, ca, cb, cop);
    check("t3_alu_a", ca, 5);
    check("t3_alu_b", cb, 3);
    check("t3_alu_op", cop, 2);
    check("t3_state", state, 1);
    check("t3_disp", disp, 15);
    check("t3_complete", complete, 0);
    check("t3_op_pending", ifc.alu_op, 0);
    press(2'b00, 4'd4);
    press(2'b10, 4'd0);
    alu_cycle(16'd19, 1'b0, 2, ca, cb, cop);
    check("t3b_alu_a", ca, 15);
    check("t3b_alu_b", cb, 4);
    check("t3b_disp", disp, 19);

    // repeat-equal with a key held during WAIT_ALU
    press(2'b10, 4'd0);
    wait_start();
    check("t4_complete_exec", complete, 0);
    ifc.key_type  = 2'b00;
    ifc.key_data  = 4'd6;
    ifc.key_valid = 1'b1;
    s0 = n_ack;
    repeat (4) @(negedge clk);
    check("t4_no_ack", ifc.key_ack, 0);
    check("t4_no_ack_cnt", n_ack - s0, 0);
    ifc.alu_result = 16'd23;
    ifc.alu_done   = 1'b1;
    @(negedge clk);
    ifc.alu_done   = 1'b0;
    check("t4_show_disp", disp, 23);
    check("t4_show_complete", complete, 1);
    begin
      int n;
      n = 0;
      while (!ifc.key_ack && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("t4_ack", ifc.key_ack, 1);
    ifc.key_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_ack_once", n_ack - s0, 1);
    check("t4_state", state, 0);
    check("t4_disp", disp, 6);

    // ALU timeout
    press(2'b01, 4'd0);
    press(2'b00, 4'd1);
    press(2'b10, 4'd0);
    wait_start();
    repeat (60) @(negedge clk);
    check("t5_still_wait", state, 4);
    check("t5_no_err_yet", error, 0);
    repeat (10) @(negedge clk);
    check("t5_error", error, 1);
    check("t5_state", state, 6);
    check("t5_disp", disp, 0);
    press(2'b00, 4'd3);
    check("t5_ign_state", state, 6);
    check("t5_ign_disp", disp, 0);
    press(2'b11, 4'd0);
    check("t5_clr_state", state, 0);
    check("t5_clr_error", error, 0);

    // overflow flag from ALU
    press(2'b00, 4'd8);
    press(2'b01, 4'd3);
    press(2'b00, 4'd0);
    press(2'b10, 4'd0);
    alu_cycle(16'd0, 1'b1, 3, ca, cb, cop);
    check("t6_state", state, 6);
    check("t6_error", error, 1);
    press(2'b11, 4'd0);

    // asynchronous reset mid-transaction
    press(2'b00, 4'd2);
    press(2'b01, 4'd0);
    press(2'b00, 4'd3);
    press(2'b10, 4'd0);
    wait_start();
    repeat (2) @(negedge clk);
    #2 nRST = 1'b1;
    #1;
    check("t7_state", state, 0);
    check("t7_alu_start", ifc.alu_start, 0);
    check("t7_key_ack", ifc.key_ack, 0);
    check("t7_alu_a", ifc.alu_a, 0);
    check("t7_alu_b", ifc.alu_b, 0);
    check("t7_disp", disp, 0);
    check("t7_complete", complete, 0);
    check("t7_error", error, 0);
    @(negedge clk);
    nRST = 1'b0;
    s0 = n_start;
    repeat (5) @(negedge clk);
    check("t7_no_restart", n_start - s0, 0);
    check("t7_state_after", state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Sequences the calculator datapath between the debounced keypad front end and a shared multi-cycle ALU. It accepts key events over a valid/ack handshake and builds signed decimal operands A and B plus an operator. It issues one start/done transaction to the ALU per evaluation and publishes the value to show and a completion flag. It replaces ad-hoc key_read looping with an explicit handshake and owns all operand and result registers.

Parameters:
WIDTH, 16, operand/result width (two's complement)
MAX_DIGITS, 4, max decimal digits per operand; further digits are acked and ignored
ALU_TIMEOUT, 64, cycles to wait for alu_done before declaring error

Ports:
clk  in  1  system clock, rising edge
nRST  in  1  asynchronous, active-high reset (asserted when 1)
key_valid  in  1  key event present; held until key_ack
key_type  in  2  00 digit, 01 operator, 10 equal, 11 clear
key_data  in  4  digit value (0-9) or operator code in [2:0]
key_ack  out  1  one-cycle pulse: key consumed
alu_start  out  1  one-cycle pulse launching an ALU operation
alu_a  out  WIDTH  operand A, stable from alu_start until alu_done
alu_b  out  WIDTH  operand B, stable from alu_start until alu_done
alu_op  out  3  operator code, stable as above
alu_done  in  1  one-cycle pulse: result valid
alu_result  in  WIDTH  ALU result, valid with alu_done
alu_ovf  in  1  overflow/div-by-zero flag, valid with alu_done
display_output  out  WIDTH  value to display
complete  out  1  high while a finished result is shown
error  out  1  high in ERR
state  out  3  encoded current state, for debug

Behaviour:
- Reset (async, nRST=1): state=ENTER_A; A, B, op, digit counts, timeout counter = 0; all outputs 0.
- States/encoding: ENTER_A=0, ENTER_OP=1, ENTER_B=2, EXEC=3, WAIT_ALU=4, SHOW=5, ERR=6.
- Key accept: the block samples a key when key_valid=1 and key_ack=0 in ENTER_A, ENTER_OP, ENTER_B, SHOW or ERR. key_ack=1 on the next cycle, coincident with the register/state update. It never accepts a key while key_ack=1.
- No key, including clear, is accepted in EXEC or WAIT_ALU. key_valid stalls, and no ack is issued.
- Digit (key_data<=9): if the operand's digit count < MAX_DIGITS, operand = operand*10 + d when operand>=0, else operand*10 - d; count++.
- Digits >9 are acked and ignored, with no change.
- Operator code 3'b111 is negate. It replaces the current operand (A in ENTER_A/ENTER_OP, B in ENTER_B) with its two's complement. The digit count is unchanged.
- ENTER_A:
  - digit -> update A.
  - operator 0-6 -> latch op, go to ENTER_OP.
  - equal -> display A, complete=1, go to SHOW.
- ENTER_OP:
  - digit -> B=d, count_B=1, go to ENTER_B.
  - operator 0-6 -> replace op.
  - equal -> acked and ignored.
- ENTER_B:
  - digit -> update B.
  - equal -> go to EXEC.
  - operator 0-6 -> go to EXEC and latch the new op as pending (chaining). After the result, the block goes to ENTER_OP with A=result, op=pending.
- EXEC: alu_start=1 for exactly one cycle, then go to WAIT_ALU and clear the timeout counter.
- WAIT_ALU: the counter increments each cycle.
  - alu_done & !alu_ovf -> A=alu_result, then SHOW (complete=1), or ENTER_OP if an op is pending.
  - alu_done & alu_ovf -> ERR.
  - counter reaches ALU_TIMEOUT-1 without alu_done -> ERR.
  - If alu_done arrives in the same cycle the counter reaches its limit, alu_done wins.
- SHOW:
  - digit -> A=d, count_A=1, B=0, complete=0, go to ENTER_A.
  - operator 0-6 -> A kept, op latched, complete=0, go to ENTER_OP.
  - equal -> re-execute with the current A, B and op (repeat-equal), via EXEC.
- ERR: error=1, display_output=0. Only clear exits; all other keys are acked and ignored.
- Clear in any accepting state: A=B=0, counts=0, pending cleared, complete=0, error=0, go to ENTER_A.
- display_output:
  - A in ENTER_A, ENTER_OP and SHOW.
  - B in ENTER_B.
  - Holds its last value in EXEC and WAIT_ALU.
  - 0 in ERR.
- Arithmetic: operand updates use WIDTH-bit wraparound. With MAX_DIGITS=4, operands stay within ±9999.
- An alu_done pulse outside WAIT_ALU is ignored.
- Reset mid-transaction aborts immediately. alu_start is not reissued.

Test Plan:
- Keys 1,2,op0(add),7,= with ALU returning 19 after 5 cycles -> one alu_start with a=12, b=7, op=0; then display_output=19, complete=1, state=5.
- Digits 9,8,7,6,5 -> A=9876, and the fifth digit is acked with no change; then negate -> display_output=-9876 (0xD96C).
- 5,op2,3,op0 with ALU returning 15 -> state=ENTER_OP, A=15, op=0, complete=0; then 4,= with ALU returning 19 -> display_output=19.
- key_valid held during WAIT_ALU -> key_ack stays 0 until alu_done, and the key is acked exactly once afterwards.
- ALU silent for ALU_TIMEOUT cycles -> error=1, state=6, display_output=0; digit ignored; clear -> state=0, error=0.
- alu_done with alu_ovf=1 -> ERR. Asserting nRST during WAIT_ALU -> all outputs 0 and state=0 asynchronously.
